// File: rtl/gobou_pkg.sv
// Shared definitions for the gobou fully-connected controller family:
// parameter defaults, sequencer states and the core-array control word.
package gobou_pkg;

  localparam int CORE_DEF    = 8;
  localparam int DWIDTH_DEF  = 16;
  localparam int LWIDTH_DEF  = 10;
  localparam int IMGSIZE_DEF = 12;
  localparam int NETSIZE_DEF = 14;

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_WEIGHT = 2'd1,
    S_BIAS   = 2'd2,
    S_OUTPUT = 2'd3
  } state_e;

  typedef struct packed {
    logic start;
    logic valid;
    logic stop;
  } ctrl_reg;

endpackage

// File: rtl/ctrl_bus.sv
// Start/valid/stop handshake between the layer controller and the MAC core array.
interface ctrl_bus;
  logic start;
  logic valid;
  logic stop;

  modport in  (input  start, input  valid, input  stop);
  modport out (output start, output valid, output stop);
endinterface

// File: rtl/fc_serial_cnt.sv
// Result serialiser counter: runs 1..CORE after each load and gates image
// writes to the number of neurons still owed in the current group.
module fc_serial_cnt
  import gobou_pkg::*;
#(
  parameter int CORE   = CORE_DEF,
  parameter int LWIDTH = LWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [LWIDTH-1:0] remaining,
  output logic              wr_en,
  output logic              last
);

  localparam int                CW     = $clog2(CORE) + 1;
  localparam logic [CW-1:0]     CORE_C = CW'(CORE);
  localparam logic [LWIDTH-1:0] CORE_L = LWIDTH'(CORE);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] active;

  always_comb begin
    active = (remaining >= CORE_L) ? CORE_C : remaining[CW-1:0];
    cnt_d  = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = CW'(1);
    end else if (cnt_q == CORE_C) begin
      cnt_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign wr_en = (cnt_q != '0) && (cnt_q <= active);
  assign last  = (cnt_q == CORE_C);

endmodule

// File: rtl/fc_ctrl_core.sv
// Layer sequencer for the gobou FC engine: streams weights/activations to CORE
// MAC cores group by group, optionally loads bias and writes results back.
module fc_ctrl_core
  import gobou_pkg::*;
#(
  parameter int CORE    = CORE_DEF,
  parameter int DWIDTH  = DWIDTH_DEF,
  parameter int LWIDTH  = LWIDTH_DEF,
  parameter int IMGSIZE = IMGSIZE_DEF,
  parameter int NETSIZE = NETSIZE_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  ctrl_bus.in                      in_ctrl,
  ctrl_bus.out                     out_ctrl,
  input  logic                     req,
  input  logic                     abort,
  input  logic                     bias_en,
  input  logic                     img_we,
  input  logic [IMGSIZE-1:0]       input_addr,
  input  logic [IMGSIZE-1:0]       output_addr,
  input  logic signed [DWIDTH-1:0] write_img,
  input  logic signed [DWIDTH-1:0] write_result,
  input  logic [$clog2(CORE):0]    net_we,
  input  logic [NETSIZE-1:0]       net_addr,
  input  logic [LWIDTH-1:0]        total_out,
  input  logic [LWIDTH-1:0]        total_in,
  output logic                     ack,
  output logic                     mem_img_we,
  output logic [IMGSIZE-1:0]       mem_img_addr,
  output logic signed [DWIDTH-1:0] write_mem_img,
  output logic [CORE-1:0]          mem_net_we,
  output logic [NETSIZE-1:0]       mem_net_addr,
  output logic                     breg_we,
  output logic                     serial_we,
  output logic [CORE-1:0]          core_mask
);

  localparam int                CW     = $clog2(CORE) + 1;
  localparam logic [CW-1:0]     CORE_C = CW'(CORE);
  localparam logic [LWIDTH-1:0] CORE_L = LWIDTH'(CORE);

  function automatic logic [CW-1:0] active_of(input logic [LWIDTH-1:0] rem);
    return (rem >= CORE_L) ? CORE_C : rem[CW-1:0];
  endfunction

  function automatic logic [CORE-1:0] mask_of(input logic [CW-1:0] act);
    logic [CORE-1:0] m;
    for (int i = 0; i < CORE; i++) m[i] = (CW'(i) < act);
    return m;
  endfunction

  state_e               state_q, state_d;
  logic                 ack_q, ack_d;
  ctrl_reg              ctrl_q, ctrl_d;
  logic                 breg_we_q, breg_we_d;
  logic                 serial_we_q, serial_we_d;
  logic [CORE-1:0]      mem_net_we_q, mem_net_we_d;
  logic [NETSIZE-1:0]   net_host_q, net_host_d;
  logic [CORE-1:0]      core_mask_q, core_mask_d;
  logic [IMGSIZE-1:0]   in_off_q, in_off_d;
  logic [IMGSIZE-1:0]   out_off_q, out_off_d;
  logic [NETSIZE-1:0]   net_off_q, net_off_d;
  logic [LWIDTH-1:0]    total_in_q, total_in_d;
  logic [LWIDTH-1:0]    total_out_q, total_out_d;
  logic                 bias_en_q, bias_en_d;
  logic [LWIDTH-1:0]    in_cnt_q, in_cnt_d;
  logic [NETSIZE-1:0]   net_cnt_q, net_cnt_d;
  logic [LWIDTH-1:0]    count_out_q, count_out_d;
  logic [IMGSIZE-1:0]   out_cnt_q, out_cnt_d;

  logic                 abort_hit;
  logic                 ser_wr, ser_last;
  logic [LWIDTH-1:0]    rem_cur, rem_nxt;
  logic [LWIDTH:0]      reach_out;

  assign abort_hit = abort && (state_q != S_WAIT);
  assign rem_cur   = total_out_q - count_out_q;
  assign rem_nxt   = rem_cur - CORE_L;
  // One extra bit so count_out + CORE cannot wrap near the top of LWIDTH.
  assign reach_out = {1'b0, count_out_q} + {1'b0, CORE_L};

  fc_serial_cnt #(
    .CORE   (CORE),
    .LWIDTH (LWIDTH)
  ) u_serial_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (abort_hit),
    .load      (serial_we_q),
    .remaining (rem_cur),
    .wr_en     (ser_wr),
    .last      (ser_last)
  );

  always_comb begin
    state_d     = state_q;
    ack_d       = ack_q;
    ctrl_d      = '0;
    breg_we_d   = 1'b0;
    serial_we_d = 1'b0;
    core_mask_d = core_mask_q;
    in_off_d    = in_off_q;
    out_off_d   = out_off_q;
    net_off_d   = net_off_q;
    total_in_d  = total_in_q;
    total_out_d = total_out_q;
    bias_en_d   = bias_en_q;
    in_cnt_d    = in_cnt_q;
    net_cnt_d   = net_cnt_q;
    count_out_d = count_out_q;
    out_cnt_d   = out_cnt_q;
    net_host_d  = net_addr;

    case (state_q)
      S_WAIT: begin
        if (req && ack_q) begin
          total_in_d  = total_in;
          total_out_d = total_out;
          bias_en_d   = bias_en;
          in_off_d    = input_addr;
          out_off_d   = output_addr;
          net_off_d   = net_addr;
          if (total_in != '0 && total_out != '0) begin
            state_d      = S_WEIGHT;
            ack_d        = 1'b0;
            ctrl_d.start = 1'b1;
            in_cnt_d     = '0;
            core_mask_d  = mask_of(active_of(total_out));
          end
        end
      end
      S_WEIGHT: begin
        ctrl_d.valid = 1'b1;
        net_cnt_d    = net_cnt_q + NETSIZE'(1);
        in_cnt_d     = in_cnt_q + LWIDTH'(1);
        if (in_cnt_q == total_in_q - LWIDTH'(1)) begin
          in_cnt_d = '0;
          if (bias_en_q) begin
            state_d = S_BIAS;
          end else begin
            state_d     = S_OUTPUT;
            ctrl_d.stop = 1'b1;
          end
        end
      end
      S_BIAS: begin
        ctrl_d.valid = 1'b1;
        ctrl_d.stop  = 1'b1;
        breg_we_d    = 1'b1;
        net_cnt_d    = net_cnt_q + NETSIZE'(1);
        state_d      = S_OUTPUT;
      end
      S_OUTPUT: begin
        serial_we_d = in_ctrl.start;
        if (ser_wr) out_cnt_d = out_cnt_q + IMGSIZE'(1);
        if (ser_last) begin
          if (reach_out >= {1'b0, total_out_q}) begin
            state_d     = S_WAIT;
            ack_d       = 1'b1;
            net_cnt_d   = '0;
            count_out_d = '0;
          end else begin
            state_d      = S_WEIGHT;
            ctrl_d.start = 1'b1;
            count_out_d  = count_out_q + CORE_L;
            core_mask_d  = mask_of(active_of(rem_nxt));
          end
        end
      end
      default: state_d = S_WAIT;
    endcase

    if (abort_hit) begin
      state_d     = S_WAIT;
      ack_d       = 1'b1;
      ctrl_d      = '0;
      breg_we_d   = 1'b0;
      serial_we_d = 1'b0;
      in_cnt_d    = '0;
      net_cnt_d   = '0;
      count_out_d = '0;
    end

    if (ack_d && !ack_q) out_cnt_d = '0;

    // Host net writes only land while the controller stays idle.
    mem_net_we_d = '0;
    if (state_q == S_WAIT && state_d == S_WAIT) begin
      for (int i = 0; i < CORE; i++) mem_net_we_d[i] = (net_we == CW'(i + 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_WAIT;
      ack_q        <= 1'b1;
      ctrl_q       <= '0;
      breg_we_q    <= 1'b0;
      serial_we_q  <= 1'b0;
      mem_net_we_q <= '0;
      net_host_q   <= '0;
      core_mask_q  <= '1;
      in_off_q     <= '0;
      out_off_q    <= '0;
      net_off_q    <= '0;
      total_in_q   <= '0;
      total_out_q  <= '0;
      bias_en_q    <= 1'b0;
      in_cnt_q     <= '0;
      net_cnt_q    <= '0;
      count_out_q  <= '0;
      out_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      ack_q        <= ack_d;
      ctrl_q       <= ctrl_d;
      breg_we_q    <= breg_we_d;
      serial_we_q  <= serial_we_d;
      mem_net_we_q <= mem_net_we_d;
      net_host_q   <= net_host_d;
      core_mask_q  <= core_mask_d;
      in_off_q     <= in_off_d;
      out_off_q    <= out_off_d;
      net_off_q    <= net_off_d;
      total_in_q   <= total_in_d;
      total_out_q  <= total_out_d;
      bias_en_q    <= bias_en_d;
      in_cnt_q     <= in_cnt_d;
      net_cnt_q    <= net_cnt_d;
      count_out_q  <= count_out_d;
      out_cnt_q    <= out_cnt_d;
    end
  end

  always_comb begin
    mem_img_we    = 1'b0;
    mem_img_addr  = '0;
    write_mem_img = write_img;
    mem_net_addr  = net_host_q;
    case (state_q)
      S_WAIT: begin
        mem_img_we   = img_we;
        mem_img_addr = img_we ? input_addr : '0;
      end
      S_WEIGHT: begin
        mem_img_addr = in_off_q + IMGSIZE'(in_cnt_q);
        mem_net_addr = net_off_q + net_cnt_q;
      end
      S_BIAS: begin
        mem_net_addr = net_off_q + net_cnt_q;
      end
      S_OUTPUT: begin
        mem_img_we    = ser_wr;
        mem_img_addr  = out_off_q + out_cnt_q;
        write_mem_img = write_result;
      end
      default: ;
    endcase
  end

  assign ack            = ack_q;
  assign out_ctrl.start = ctrl_q.start;
  assign out_ctrl.valid = ctrl_q.valid;
  assign out_ctrl.stop  = ctrl_q.stop;
  assign breg_we        = breg_we_q;
  assign serial_we      = serial_we_q;
  assign mem_net_we     = mem_net_we_q;
  assign core_mask      = core_mask_q;

endmodule

// File: tb/tb_fc_ctrl_core.sv
// Scoreboard bench for fc_ctrl_core with CORE=4 and a simple fixed-latency core model.
module tb_fc_ctrl_core;

  localparam int CORE    = 4;
  localparam int DWIDTH  = 16;
  localparam int LWIDTH  = 10;
  localparam int IMGSIZE = 12;
  localparam int NETSIZE = 14;
  localparam int CW      = $clog2(CORE) + 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               req, abort, bias_en, img_we;
  logic [IMGSIZE-1:0] input_addr, output_addr;
  logic [DWIDTH-1:0]  write_img, write_result;
  logic [CW-1:0]      net_we;
  logic [NETSIZE-1:0] net_addr;
  logic [LWIDTH-1:0]  total_out, total_in;
  logic               ack, mem_img_we, breg_we, serial_we;
  logic [IMGSIZE-1:0] mem_img_addr;
  logic [DWIDTH-1:0]  write_mem_img;
  logic [CORE-1:0]    mem_net_we, core_mask;
  logic [NETSIZE-1:0] mem_net_addr;

  ctrl_bus in_bus ();
  ctrl_bus out_bus ();

  fc_ctrl_core #(
    .CORE(CORE), .DWIDTH(DWIDTH), .LWIDTH(LWIDTH), .IMGSIZE(IMGSIZE), .NETSIZE(NETSIZE)
  ) dut (
    .clk(clk), .rst(rst), .in_ctrl(in_bus), .out_ctrl(out_bus),
    .req(req), .abort(abort), .bias_en(bias_en), .img_we(img_we),
    .input_addr(input_addr), .output_addr(output_addr),
    .write_img(write_img), .write_result(write_result),
    .net_we(net_we), .net_addr(net_addr), .total_out(total_out), .total_in(total_in),
    .ack(ack), .mem_img_we(mem_img_we), .mem_img_addr(mem_img_addr),
    .write_mem_img(write_mem_img), .mem_net_we(mem_net_we), .mem_net_addr(mem_net_addr),
    .breg_we(breg_we), .serial_we(serial_we), .core_mask(core_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IMGSIZE-1:0] addr;
    logic [DWIDTH-1:0]  data;
  } img_t;

  img_t               img_q[$];
  logic [NETSIZE-1:0] net_q[$];
  logic [CORE-1:0]    mask_q[$];
  int checks = 0;
  int errors = 0;

  task automatic idle_inputs();
    req = 1'b0; abort = 1'b0; bias_en = 1'b0; img_we = 1'b0;
    input_addr = '0; output_addr = '0; write_img = 16'h5555; write_result = '0;
    net_we = '0; net_addr = '0; total_out = '0; total_in = '0;
    in_bus.start = 1'b0; in_bus.valid = 1'b0; in_bus.stop = 1'b0;
  endtask

  task automatic issue_req(input int ti, input int to, input int b,
                           input int ioff, input int ooff, input int noff);
    @(negedge clk);
    total_in = LWIDTH'(ti); total_out = LWIDTH'(to); bias_en = (b != 0);
    input_addr = IMGSIZE'(ioff); output_addr = IMGSIZE'(ooff); net_addr = NETSIZE'(noff);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic run_layer(input string tag, input int ti, input int to, input int b,
                           input int ioff, input int ooff, input int noff, input int lat);
    int g, words, starts, stops, bregs, writes, vcnt, tmr, cyc, last_wr, ack_cyc, act_last, bad_nwe;
    bit done;
    logic [NETSIZE-1:0] prev_net, exp_net;
    logic [IMGSIZE-1:0] prev_img;
    logic [CORE-1:0]    exp_m;
    img_t               exp_i;
    g = (to + CORE - 1) / CORE;
    words = ti + b;
    starts = 0; stops = 0; bregs = 0; writes = 0; vcnt = 0; tmr = 0; cyc = 0;
    last_wr = 0; ack_cyc = 0; bad_nwe = 0; done = 1'b0;
    prev_net = '0; prev_img = '0;
    act_last = to - (g - 1) * CORE;
    for (int n = 0; n < to; n++) begin
      exp_i.addr = IMGSIZE'(ooff + n);
      exp_i.data = DWIDTH'(32'hA000 + n);
      img_q.push_back(exp_i);
    end
    for (int i = 0; i < g * words; i++) net_q.push_back(NETSIZE'(noff + i));
    for (int k = 0; k < g; k++) begin
      int act;
      act = (to - k * CORE >= CORE) ? CORE : to - k * CORE;
      mask_q.push_back(CORE'((1 << act) - 1));
    end
    write_result = 16'hA000;
    issue_req(ti, to, b, ioff, ooff, noff);
    while (!done && cyc < 800) begin
      if (out_bus.start) begin
        starts++;
        vcnt = 0;
        if (mask_q.size() > 0) begin
          exp_m = mask_q.pop_front();
          checks++;
          if (core_mask !== exp_m)
            $display("FAIL %s_core_mask got %b exp %b", tag, core_mask, exp_m);
          if (core_mask !== exp_m) errors++;
        end
      end
      if (out_bus.valid) begin
        vcnt++;
        checks++;
        if (net_q.size() == 0) begin
          errors++;
          $display("FAIL %s_net_extra got %0h exp none", tag, prev_net);
        end else begin
          exp_net = net_q.pop_front();
          if (prev_net !== exp_net) begin
            errors++;
            $display("FAIL %s_net_addr got %0h exp %0h", tag, prev_net, exp_net);
          end
        end
        if (vcnt <= ti) begin
          checks++;
          if (prev_img !== IMGSIZE'(ioff + vcnt - 1)) begin
            errors++;
            $display("FAIL %s_in_addr got %0h exp %0h", tag, prev_img, IMGSIZE'(ioff + vcnt - 1));
          end
        end
        checks++;
        if (out_bus.stop !== (vcnt == words)) begin
          errors++;
          $display("FAIL %s_stop_timing got %b exp %b", tag, out_bus.stop, (vcnt == words));
        end
        checks++;
        if (breg_we !== (b != 0 && vcnt == words)) begin
          errors++;
          $display("FAIL %s_breg_timing got %b exp %b", tag, breg_we, (b != 0 && vcnt == words));
        end
      end
      if (out_bus.stop) stops++;
      if (breg_we) bregs++;
      if (mem_net_we !== '0) bad_nwe++;
      if (mem_img_we) begin
        last_wr = cyc;
        checks++;
        if (img_q.size() == 0) begin
          errors++;
          $display("FAIL %s_img_extra got %0h exp none", tag, mem_img_addr);
        end else begin
          exp_i = img_q.pop_front();
          if (mem_img_addr !== exp_i.addr || write_mem_img !== exp_i.data) begin
            errors++;
            $display("FAIL %s_img_write got %0h:%0h exp %0h:%0h", tag,
                     mem_img_addr, write_mem_img, exp_i.addr, exp_i.data);
          end
        end
        writes++;
      end
      prev_net = mem_net_addr;
      prev_img = mem_img_addr;
      if (ack) begin
        done = 1'b1;
        ack_cyc = cyc;
      end else begin
        in_bus.start = 1'b0;
        if (tmr > 0) begin
          tmr--;
          if (tmr == 0) in_bus.start = 1'b1;
        end
        if (out_bus.stop) tmr = lat;
        write_result = DWIDTH'(32'hA000 + writes);
        @(negedge clk);
        cyc++;
      end
    end
    in_bus.start = 1'b0;
    checks++;
    if (!done) begin errors++; $display("FAIL %s_ack_timeout got 0 exp 1", tag); end
    checks++;
    if (starts != g) begin errors++; $display("FAIL %s_starts got %0d exp %0d", tag, starts, g); end
    checks++;
    if (stops != g) begin errors++; $display("FAIL %s_stops got %0d exp %0d", tag, stops, g); end
    checks++;
    if (bregs != (b != 0 ? g : 0)) begin
      errors++; $display("FAIL %s_breg_count got %0d exp %0d", tag, bregs, (b != 0 ? g : 0));
    end
    checks++;
    if (writes != to) begin errors++; $display("FAIL %s_writes got %0d exp %0d", tag, writes, to); end
    checks++;
    if (done && (ack_cyc - last_wr != CORE - act_last + 1)) begin
      errors++;
      $display("FAIL %s_ack_latency got %0d exp %0d", tag, ack_cyc - last_wr, CORE - act_last + 1);
    end
    checks++;
    if (bad_nwe != 0) begin errors++; $display("FAIL %s_net_we_busy got %0d exp 0", tag, bad_nwe); end
    checks++;
    if (img_q.size() + net_q.size() + mask_q.size() != 0) begin
      errors++;
      $display("FAIL %s_leftover got %0d/%0d/%0d exp 0/0/0", tag, img_q.size(), net_q.size(), mask_q.size());
    end
    img_q.delete(); net_q.delete(); mask_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (ack !== 1'b1 || out_bus.start !== 1'b0 || out_bus.valid !== 1'b0 || out_bus.stop !== 1'b0 ||
        breg_we !== 1'b0 || serial_we !== 1'b0 || mem_img_we !== 1'b0 || mem_net_we !== '0 ||
        core_mask !== 4'b1111) begin
      errors++;
      $display("FAIL %s got ack=%b st=%b va=%b sp=%b bw=%b sw=%b iw=%b nw=%b m=%b exp ack=1 m=1111 rest 0",
               tag, ack, out_bus.start, out_bus.valid, out_bus.stop, breg_we, serial_we,
               mem_img_we, mem_net_we, core_mask);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_values");
    checks++;
    if (mem_net_addr !== '0 || mem_img_addr !== '0) begin
      errors++;
      $display("FAIL reset_addr got %0h/%0h exp 0/0", mem_net_addr, mem_img_addr);
    end
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("idle_after_reset");
  endtask

  task automatic test_two_groups_bias();
    run_layer("two_groups", 3, 8, 1, 12'h010, 12'h200, 0, 3);
  endtask

  task automatic test_partial_group();
    run_layer("partial", 3, 6, 1, 12'h020, 12'h300, 14'h080, 2);
  endtask

  task automatic test_bias_off();
    run_layer("bias_off", 2, 8, 0, 12'h030, 12'h400, 14'h100, 4);
  endtask

  task automatic test_zero_size();
    issue_req(0, 5, 1, 1, 2, 3);
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (ack !== 1'b1 || out_bus.start !== 1'b0 || mem_img_we !== 1'b0 || mem_net_we !== '0) begin
        errors++;
        $display("FAIL zero_size cycle %0d got ack=%b start=%b iw=%b nw=%b exp 1/0/0/0",
                 c, ack, out_bus.start, mem_img_we, mem_net_we);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_abort();
    issue_req(6, 4, 1, 12'h040, 12'h500, 14'h200);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (ack !== 1'b1 || mem_img_we !== 1'b0 || out_bus.valid !== 1'b0 || out_bus.stop !== 1'b0) begin
      errors++;
      $display("FAIL abort_state got ack=%b iw=%b valid=%b stop=%b exp 1/0/0/0",
               ack, mem_img_we, out_bus.valid, out_bus.stop);
    end
    run_layer("after_abort", 2, 4, 0, 12'h050, 12'h600, 14'h040, 2);
  endtask

  task automatic test_back_to_back();
    run_layer("b2b_first", 1, 3, 0, 12'h060, 12'h700, 14'h300, 1);
    run_layer("b2b_second", 4, 5, 1, 12'h070, 12'h710, 14'h3F0, 3);
  endtask

  task automatic test_reset_in_output();
    int cyc;
    issue_req(2, 4, 0, 12'h080, 12'h800, 14'h010);
    cyc = 0;
    while (!out_bus.stop && cyc < 50) begin @(negedge clk); cyc++; end
    checks++;
    if (!out_bus.stop) begin errors++; $display("FAIL rst_out_stop_timeout got 0 exp 1"); end
    in_bus.start = 1'b1;
    @(negedge clk);
    in_bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_img_we !== 1'b1) begin errors++; $display("FAIL rst_out_writing got %b exp 1", mem_img_we); end
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset_in_output");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_host_writes();
    net_we = CW'(5);
    @(negedge clk);
    checks++;
    if (mem_net_we !== '0) begin errors++; $display("FAIL net_we_oob got %b exp 0000", mem_net_we); end
    net_we = CW'(2);
    @(negedge clk);
    checks++;
    if (mem_net_we !== 4'b0010) begin errors++; $display("FAIL net_we_decode got %b exp 0010", mem_net_we); end
    net_we = '0;
    img_we = 1'b1; input_addr = 12'h055; write_img = 16'h1234;
    #1;
    checks++;
    if (mem_img_we !== 1'b1 || mem_img_addr !== 12'h055 || write_mem_img !== 16'h1234) begin
      errors++;
      $display("FAIL host_img got %b %0h %0h exp 1 55 1234", mem_img_we, mem_img_addr, write_mem_img);
    end
    @(negedge clk);
    img_we = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_two_groups_bias();
    test_partial_group();
    test_bias_off();
    test_zero_size();
    test_abort();
    test_back_to_back();
    test_reset_in_output();
    test_host_writes();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fc_ctrl_core.md
# fc_ctrl_core

Parametrised successor controller for the gobou fully-connected engine. It sequences one layer: it streams input activations and weights to CORE parallel MAC cores, optionally loads bias, and serialises the CORE results back into image memory, looping over output groups until `total_out` neurons are produced. It adds four things: a partial final group with a core mask, optional bias, abort, and zero-size layer handling. It sits between the layer sequencer (req/ack) and the image/net memories plus the core array (ctrl_bus).

## Interface
- CORE, 8, number of MAC cores (≥2)
- DWIDTH, 16, signed data width
- LWIDTH, 10, layer-size counter width
- IMGSIZE, 12, image memory address width
- NETSIZE, 14, net memory address width
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high (one clock domain)
- in_ctrl  ctrl_bus.in  —  start/valid/stop from the core array; only start is used
- out_ctrl  ctrl_bus.out  —  start/valid/stop to the core array
- req  in  1  layer start; sampled only in S_WAIT with ack=1
- abort  in  1  cancel the current layer
- bias_en  in  1  bias phase enable; latched on an accepted req
- img_we  in  1  host image write, passed through in S_WAIT
- input_addr, output_addr  in  IMGSIZE  image base addresses
- write_img  in  DWIDTH  host image data
- write_result  in  DWIDTH  serialised core result
- net_we  in  $clog2(CORE)+1  host net write select: 0 means none, i in 1..CORE selects core i-1, anything larger means none
- net_addr  in  NETSIZE  net base address
- total_out, total_in  in  LWIDTH  neuron counts
- ack  out  1  idle/done
- mem_img_we  out  1
- mem_img_addr  out  IMGSIZE
- write_mem_img  out  DWIDTH
- mem_net_we  out  CORE  one-hot
- mem_net_addr  out  NETSIZE
- breg_we  out  1  bias register load
- serial_we  out  1  serialiser load
- core_mask  out  CORE  active cores in the current group

## Operation
- States: S_WAIT, S_WEIGHT, S_BIAS, S_OUTPUT.
- Reset values:
  - ack=1; state S_WAIT.
  - All other outputs, counters and latched registers are 0, except core_mask, which resets to all-ones.
- Accepting a request (S_WAIT, ack=1, req=1):
  - Latch totals, bias_en and the three base offsets.
  - If total_in=0 or total_out=0, stay in S_WAIT. No start pulse is issued and ack stays 1.
  - Otherwise go to S_WEIGHT, drop ack, and pulse out_ctrl.start.
- S_WEIGHT: runs for total_in cycles. In cycle k:
  - mem_img_addr = in_off + k
  - mem_net_addr = net_off + net_cnt, and net_cnt increments each cycle.
  - After the last cycle, go to S_BIAS if bias_en, else S_OUTPUT.
- S_BIAS: one cycle; net_cnt increments; then S_OUTPUT.
- S_OUTPUT:
  - Wait for in_ctrl.start.
  - serial_cnt runs 1..CORE, starting the cycle after serial_we.
  - mem_img_we is asserted on exactly `active` consecutive cycles. The first write is the cycle after serial_we.
  - active = min(CORE, total_out − count_out).
  - The group ends when serial_cnt = CORE.
- Group loop:
  - If count_out + CORE ≥ total_out: go to S_WAIT, set ack, clear net_cnt and count_out.
  - Otherwise: count_out += CORE, pulse start, return to S_WEIGHT. net_cnt carries on across groups.
- core_mask: bit i = (i < active). Registered on entry to S_WEIGHT.
- Image path:
  - In S_OUTPUT: mem_img_addr = out_off + out_cnt, and write_mem_img = write_result.
  - Elsewhere: write_mem_img = write_img.
  - out_cnt increments on every mem_img_we in S_OUTPUT and clears when ack rises.
- Net write: mem_net_we is a registered decode of net_we. It is honoured in S_WAIT only and forced to 0 otherwise.
- Abort (any non-WAIT state):
  - Next cycle: S_WAIT, ack=1, all counters cleared.
  - mem_img_we and mem_net_we are 0 from that cycle on.
  - No stop is issued.
  - Abort in S_WAIT is ignored. Abort takes priority over every other transition.
- req while ack=0 is ignored.

## Timing
- out_ctrl.start: req is accepted at cycle t, start is high at t+1.
- out_ctrl.valid: registered, high the cycle after each S_WEIGHT/S_BIAS cycle.
- out_ctrl.stop: one-cycle pulse the cycle after the final compute cycle (the bias cycle if bias_en, else the last weight cycle).
- breg_we: high the cycle after S_BIAS.
- serial_we: in_ctrl.start delayed by one cycle.
- ack: rises the cycle after the last group ends (serial_cnt = CORE).
- Layer latency with G = ceil(total_out/CORE) groups: G·(total_in + bias_en + CORE + core latency + 2) cycles.
- Net words per group: total_in + bias_en. Wrap-around of mem_net_addr is modulo 2^NETSIZE.

## Structure
- Shared package `gobou_pkg`: parameter defaults, the state enum, and a ctrl_reg struct.
- One sub-module, `fc_serial_cnt`: serial counter plus active-length write gating, with CORE and LWIDTH as parameters.

## Test plan
All scenarios use CORE=4.
- Two full groups, bias on: total_in=3, total_out=8, bias_en=1 → 2 start pulses; stop after each bias cycle; net addresses 0..7; 8 image writes at out_off..out_off+7; ack returns.
- Partial final group: total_out=6 → core_mask 1111 then 0011; exactly 6 image writes.
- Bias off: bias_en=0, total_in=2 → no breg_we; stop follows the 2nd weight cycle; net_cnt steps by 2 per group.
- Zero-size layer: total_in=0, total_out=5 → ack stays 1, no start pulse, no memory writes.
- Abort mid S_WEIGHT, then a fresh req → ack=1 the next cycle; the second layer's first net address equals net_off.
- Reset asserted during S_OUTPUT → all outputs at reset values immediately (asynchronous); net_we=5 while in S_WAIT → mem_net_we=0.
